// File: rtl/gtfwizard_mac_example_prbs_chk.sv
`default_nettype none
// ============================================================================
// Module  : gtfwizard_mac_example_prbs_chk
// Brief   : Self-seeding PRBS31 (x^31+x^28+1) checker for the GTF RX user
//           data path. It locks to the stream, counts errors and drives a
//           registered data-good flag. Optional macro:
//           GTFWIZARD_PRBS_BIT_ERR_CNT_EN selects per-bit error counting
//           instead of per-word counting.
// Revision: 1.0 - initial release
// ============================================================================
module gtfwizard_mac_example_prbs_chk #(
   parameter int P_DATA_WIDTH  = 64,
   parameter int P_LOCK_WORDS  = 4,
   parameter int P_UNLOCK_ERRS = 4,
   parameter int P_GOOD_WINDOW = 8
) (
   input  logic                    rx_usrclk_in,
   input  logic                    rx_rst_n_in,
   input  logic                    prbs_en_in,
   input  logic [P_DATA_WIDTH-1:0] rx_data_in,
   input  logic                    rx_data_valid_in,
   input  logic                    err_cnt_clr_in,
   output logic                    prbs_locked_out,
   output logic                    rx_data_good_out,
   output logic [31:0]             err_cnt_out,
   output logic                    err_sticky_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] c_lock_last   = 4'(P_LOCK_WORDS - 1);
   localparam logic [3:0] c_unlock_last = 4'(P_UNLOCK_ERRS - 1);

   state_t                   r_state;
   logic [30:0]              r_lfsr;
   logic [4:0]               r_fill;
   logic                     r_s1_valid;
   logic                     r_s1_cmp_ok;
   logic [P_DATA_WIDTH-1:0]  r_s1_mis;
   logic [3:0]               r_lock_cnt;
   logic [3:0]               r_unlock_cnt;
   logic [P_GOOD_WINDOW-1:0] r_hist;
   logic [31:0]              r_err_cnt;
   logic                     r_err_sticky;
   logic                     r_locked;
   logic                     r_good;

   logic [P_DATA_WIDTH-1:0]  w_exp;
   logic [30:0]              w_pred;
   logic [30:0]              w_load;
   logic [7:0]               w_fill_sum;
   logic [4:0]               w_fill_next;

   // State bit k holds d[n-31+k]: bit 30 is the newest bit, bit 0 the oldest.
   always_comb begin
      w_pred = r_lfsr;
      w_load = r_lfsr;
      w_exp  = '0;
      for (int i = 0; i < P_DATA_WIDTH; i++) begin
         w_exp[i] = w_pred[0] ^ w_pred[3];
         w_pred   = {w_exp[i], w_pred[30:1]};
         w_load   = {rx_data_in[i], w_load[30:1]};
      end
   end

   assign w_fill_sum  = 8'(r_fill) + 8'(P_DATA_WIDTH);
   assign w_fill_next = (w_fill_sum >= 8'd31) ? 5'd31 : w_fill_sum[4:0];

   // Stage 1: prediction, mismatch capture and LFSR advance.
   always_ff @(posedge rx_usrclk_in or negedge rx_rst_n_in) begin
      if (!rx_rst_n_in) begin
         r_lfsr      <= '0;
         r_fill      <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_cmp_ok <= 1'b0;
         r_s1_mis    <= '0;
      end else if (r_state == ST_IDLE) begin
         r_lfsr      <= '0;
         r_fill      <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_cmp_ok <= 1'b0;
      end else begin
         r_s1_valid <= rx_data_valid_in;
         if (rx_data_valid_in) begin
            r_s1_mis    <= w_exp ^ rx_data_in;
            // A prediction only counts towards lock when it came from a full,
            // non-zero seed; words predicted in free-run mode never do.
            r_s1_cmp_ok <= (r_state == ST_SEED) && (r_fill == 5'd31) && (r_lfsr != '0);
            r_lfsr      <= (r_state == ST_LOCKED) ? w_pred : w_load;
            r_fill      <= w_fill_next;
         end
      end
   end

   logic                     w_word_err;
   logic [31:0]              w_inc;
   logic [32:0]              w_cnt_sum;
   logic [31:0]              w_cnt_sat;

   assign w_word_err = |r_s1_mis;

`ifdef GTFWIZARD_PRBS_BIT_ERR_CNT_EN
   always_comb begin
      w_inc = '0;
      for (int i = 0; i < P_DATA_WIDTH; i++) begin
         w_inc = w_inc + 32'(r_s1_mis[i]);
      end
   end
`else
   assign w_inc = {31'd0, w_word_err};
`endif

   assign w_cnt_sum = {1'b0, r_err_cnt} + {1'b0, w_inc};
   assign w_cnt_sat = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];

   state_t                   w_state_nx;
   logic [3:0]               w_lock_nx;
   logic [3:0]               w_unlock_nx;
   logic [P_GOOD_WINDOW-1:0] w_hist_nx;
   logic [P_GOOD_WINDOW-1:0] w_hist_shift;
   logic [31:0]              w_cnt_nx;
   logic                     w_sticky_nx;
   logic                     w_locked_nx;
   logic                     w_good_nx;

   always_comb begin
      w_hist_shift    = r_hist << 1;
      w_hist_shift[0] = w_word_err;
      w_state_nx      = r_state;
      w_lock_nx       = r_lock_cnt;
      w_unlock_nx     = r_unlock_cnt;
      w_hist_nx       = r_hist;
      w_cnt_nx        = r_err_cnt;
      w_sticky_nx     = r_err_sticky;
      if (!prbs_en_in) begin
         w_state_nx  = ST_IDLE;
         w_lock_nx   = '0;
         w_unlock_nx = '0;
         w_hist_nx   = '1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nx = ST_SEED;
            end
            ST_SEED: begin
               if (r_s1_valid) begin
                  if (r_s1_cmp_ok && !w_word_err) begin
                     // History stays dirty through lock, so data-good needs a
                     // full window of clean words observed while locked.
                     if (r_lock_cnt == c_lock_last) begin
                        w_state_nx  = ST_LOCKED;
                        w_lock_nx   = '0;
                        w_unlock_nx = '0;
                     end else begin
                        w_lock_nx = r_lock_cnt + 4'd1;
                     end
                  end else begin
                     w_lock_nx = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (r_s1_valid) begin
                  w_hist_nx   = w_hist_shift;
                  w_cnt_nx    = w_cnt_sat;
                  w_sticky_nx = r_err_sticky | w_word_err;
                  if (w_word_err) begin
                     if (r_unlock_cnt == c_unlock_last) begin
                        w_state_nx  = ST_SEED;
                        w_hist_nx   = '1;
                        w_unlock_nx = '0;
                        w_lock_nx   = '0;
                     end else begin
                        w_unlock_nx = r_unlock_cnt + 4'd1;
                     end
                  end else begin
                     w_unlock_nx = '0;
                  end
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end
      if (err_cnt_clr_in) begin
         w_cnt_nx    = '0;
         w_sticky_nx = 1'b0;
      end
      w_locked_nx = (w_state_nx == ST_LOCKED);
      w_good_nx   = w_locked_nx && (w_hist_nx == '0);
   end

   // Stage 2: state machine, counters, history and registered outputs.
   always_ff @(posedge rx_usrclk_in or negedge rx_rst_n_in) begin
      if (!rx_rst_n_in) begin
         r_state      <= ST_IDLE;
         r_lock_cnt   <= '0;
         r_unlock_cnt <= '0;
         r_hist       <= '1;
         r_err_cnt    <= '0;
         r_err_sticky <= 1'b0;
         r_locked     <= 1'b0;
         r_good       <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_lock_cnt   <= w_lock_nx;
         r_unlock_cnt <= w_unlock_nx;
         r_hist       <= w_hist_nx;
         r_err_cnt    <= w_cnt_nx;
         r_err_sticky <= w_sticky_nx;
         r_locked     <= w_locked_nx;
         r_good       <= w_good_nx;
      end
   end

   assign prbs_locked_out  = r_locked;
   assign rx_data_good_out = r_good;
   assign err_cnt_out      = r_err_cnt;
   assign err_sticky_out   = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_gtfwizard_mac_example_prbs_chk.sv
`default_nettype none
// ============================================================================
// Module  : tb_gtfwizard_mac_example_prbs_chk
// Brief   : Directed bench for the PRBS31 checker: lock, data-good window,
//           error counting, relock, clear priority, saturation, async reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gtfwizard_mac_example_prbs_chk;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [W-1:0]  data;
   logic          valid;
   logic          clr;
   logic          locked;
   logic          good;
   logic [31:0]   cnt;
   logic          sticky;

   int            total = 0;
   int            bad   = 0;
   logic [30:0]   gen;
   logic [W-1:0]  m1;
   logic [W-1:0]  m3;

`ifdef GTFWIZARD_PRBS_BIT_ERR_CNT_EN
   localparam logic [31:0] c_cnt3 = 32'd9;
   localparam logic [31:0] c_cnt4 = 32'd12;
`else
   localparam logic [31:0] c_cnt3 = 32'd3;
   localparam logic [31:0] c_cnt4 = 32'd4;
`endif

   always #5 clk = ~clk;

   gtfwizard_mac_example_prbs_chk #(
      .P_DATA_WIDTH  (W),
      .P_LOCK_WORDS  (4),
      .P_UNLOCK_ERRS (4),
      .P_GOOD_WINDOW (8)
   ) dut (
      .rx_usrclk_in     (clk),
      .rx_rst_n_in      (rst_n),
      .prbs_en_in       (en),
      .rx_data_in       (data),
      .rx_data_valid_in (valid),
      .err_cnt_clr_in   (clr),
      .prbs_locked_out  (locked),
      .rx_data_good_out (good),
      .err_cnt_out      (cnt),
      .err_sticky_out   (sticky)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic l, input logic g,
                          input logic [31:0] c, input logic s);
      chk({tag, "/locked"}, {31'd0, locked}, {31'd0, l});
      chk({tag, "/good"},   {31'd0, good},   {31'd0, g});
      chk({tag, "/cnt"},    cnt,             c);
      chk({tag, "/sticky"}, {31'd0, sticky}, {31'd0, s});
   endtask

   // Reference stream: gen[k] = d[n-1-k], d[n] = d[n-31] ^ d[n-28].
   task automatic next_word(output logic [W-1:0] w);
      logic b;
      for (int i = 0; i < W; i++) begin
         b    = gen[30] ^ gen[27];
         w[i] = b;
         gen  = {gen[29:0], b};
      end
   endtask

   task automatic send(input logic [W-1:0] w);
      data  = w;
      valid = 1'b1;
      tick();
   endtask

   task automatic send_prbs(input logic [W-1:0] flip);
      logic [W-1:0] w;
      next_word(w);
      send(w ^ flip);
   endtask

   task automatic idle();
      valid = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      valid = 1'b0;
      clr   = 1'b0;
      data  = '0;
      gen   = 31'h7FFF_FFFF;
      m1    = '0;
      m1[17] = 1'b1;
      m3    = '0;
      m3[0] = 1'b1;
      m3[20] = 1'b1;
      m3[63] = 1'b1;

      repeat (3) tick();
      chk_all("reset", 1'b0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b1;
      tick();
      en = 1'b1;
      tick();
      tick();

      // Lock: seed word w1 plus four matching words; outputs lag by two edges.
      for (int k = 1; k <= 5; k++) send_prbs('0);
      chk("pre_lock", {31'd0, locked}, 32'd0);
      send_prbs('0);
      chk_all("lock", 1'b1, 1'b0, 32'd0, 1'b0);
      for (int k = 7; k <= 13; k++) send_prbs('0);
      chk("good_pre", {31'd0, good}, 32'd0);
      send_prbs('0);
      chk("good_rise", {31'd0, good}, 32'd1);

      // Single flipped bit while locked.
      send_prbs(m1);
      chk("good_before_flip", {31'd0, good}, 32'd1);
      send_prbs('0);
      chk_all("flip", 1'b1, 1'b0, 32'd1, 1'b1);
      for (int k = 17; k <= 23; k++) send_prbs('0);
      chk("flip_good_hold", {31'd0, good}, 32'd0);
      send_prbs('0);
      chk_all("flip_good_back", 1'b1, 1'b1, 32'd1, 1'b1);

      clr = 1'b1;
      idle();
      clr = 1'b0;
      chk_all("clear", 1'b1, 1'b1, 32'd0, 1'b0);

      // Four corrupted words with three flipped bits each force relock.
      for (int k = 25; k <= 28; k++) send_prbs(m3);
      chk_all("burst3", 1'b1, 1'b0, c_cnt3, 1'b1);
      send_prbs('0);
      chk_all("unlock", 1'b0, 1'b0, c_cnt4, 1'b1);
      for (int k = 30; k <= 33; k++) send_prbs('0);
      chk("relock_pre", {31'd0, locked}, 32'd0);
      send_prbs('0);
      chk("relock", {31'd0, locked}, 32'd1);

      // Clear in the same cycle as an increment wins.
      send_prbs(m1);
      chk("cnt_before_clr", cnt, c_cnt4);
      clr = 1'b1;
      send_prbs('0);
      clr = 1'b0;
      chk_all("clr_vs_inc", 1'b1, 1'b0, 32'd0, 1'b0);

      // Saturation from a preset near the top.
      dut.r_err_cnt <= 32'hFFFF_FFFE;
      send_prbs(m1);
      send_prbs(m1);
      chk("sat_first", cnt, 32'hFFFF_FFFF);
      send_prbs(m1);
      send_prbs('0);
      chk_all("sat_hold", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
      send_prbs('0);

      // Asynchronous reset mid-lock, observed before the next clock edge.
      chk("pre_rst_locked", {31'd0, locked}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 32'd0, 1'b0);
      valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // All-zero stream never locks; a real stream afterwards does.
      for (int k = 0; k < 12; k++) send('0);
      chk_all("zeros", 1'b0, 1'b0, 32'd0, 1'b0);
      for (int k = 1; k <= 5; k++) send_prbs('0);
      chk("zero_then_prbs_pre", {31'd0, locked}, 32'd0);
      send_prbs('0);
      chk("zero_then_prbs_lock", {31'd0, locked}, 32'd1);

      // Disable while locked: lock drops next cycle, counters hold.
      send_prbs(m1);
      send_prbs('0);
      chk_all("pre_disable", 1'b1, 1'b0, 32'd1, 1'b1);
      en = 1'b0;
      idle();
      chk_all("disable", 1'b0, 1'b0, 32'd1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
